regfile_multiport_sb: RTL and testbench

- Parametrised general-purpose register file for the pipelined MIPS32 core.
- Successor to the fixed 32x32, 2-read/1-write file. Adds:
  - configurable width, depth and read-port count
  - asynchronous clearing reset
  - optional write-to-read bypass
  - per-register pending-write scoreboard for decode-stage hazard detection
- Sits between decode (reads, reservations) and writeback (writes).

---
 rtl/regfile_multiport_sb.sv | 59 +++++
 tb/tb_regfile_multiport_sb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport_sb.sv
// regfile_multiport_sb: parametrised multi-read register file with write bypass and pending-write scoreboard
module regfile_multiport_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy, busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wr_ok, rsv_ok;
  assign wr_ok  = reset && wr_en && !(ZERO_REG != 0 && wr_addr == '0);
  assign rsv_ok = reset && rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_nxt[i] = (rsv_ok && rsv_addr == ADDR_W'(i)) ? 1'b1 :
                    flush                               ? 1'b0 :
                    (wr_ok && wr_addr == ADDR_W'(i))    ? 1'b0 : busy[i];
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_ok) regs[wr_addr] <= wr_data;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              z, fwd;
    assign a   = rd_addr[k*ADDR_W +: ADDR_W];
    assign z   = ZERO_REG != 0 && a == '0;
    assign fwd = BYPASS != 0 && wr_ok && wr_addr == a;
    assign rd_data[k*DATA_W +: DATA_W] = z ? '0 : fwd ? wr_data : regs[a];
    assign rd_busy[k] = !z && !fwd && busy[a];
  end
endmodule

// File: tb/tb_regfile_multiport_sb.sv
// tb_regfile_multiport_sb: default-config and wide/3-port/no-bypass instances checked against a behavioural model
module tb_regfile_multiport_sb;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;
  logic [9:0]   a_rd_addr;
  logic [63:0]  a_rd_data;
  logic [1:0]   a_rd_busy;
  logic         a_wr_en, a_rsv_en, a_flush;
  logic [4:0]   a_wr_addr, a_rsv_addr;
  logic [31:0]  a_wr_data;
  logic [5:0]   a_busy_cnt;
  logic [11:0]  b_rd_addr;
  logic [191:0] b_rd_data;
  logic [2:0]   b_rd_busy;
  logic         b_wr_en, b_rsv_en, b_flush;
  logic [3:0]   b_wr_addr, b_rsv_addr;
  logic [63:0]  b_wr_data;
  logic [4:0]   b_busy_cnt;
  regfile_multiport_sb dut_a (
    .clk(clk), .reset(reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .rsv_en(a_rsv_en),
    .rsv_addr(a_rsv_addr), .flush(a_flush), .busy_cnt(a_busy_cnt)
  );
  regfile_multiport_sb #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .rsv_en(b_rsv_en),
    .rsv_addr(b_rsv_addr), .flush(b_flush), .busy_cnt(b_busy_cnt)
  );
  logic [31:0] ma_reg [32];
  bit          ma_busy [32];
  logic [63:0] mb_reg [16];
  bit          mb_busy [16];
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask
  task automatic model_clear();
    foreach (ma_reg[i]) begin
      ma_reg[i]  = '0;
      ma_busy[i] = 0;
    end
    foreach (mb_reg[i]) begin
      mb_reg[i]  = '0;
      mb_busy[i] = 0;
    end
  endtask
  always @(negedge reset) model_clear();
  always @(posedge clk) begin
    if (!reset) model_clear();
    else begin
      if (a_flush) foreach (ma_busy[i]) ma_busy[i] = 0;
      if (a_wr_en && a_wr_addr != 0) begin
        ma_reg[a_wr_addr]  = a_wr_data;
        ma_busy[a_wr_addr] = 0;
      end
      if (a_rsv_en && a_rsv_addr != 0) ma_busy[a_rsv_addr] = 1;
      if (b_flush) foreach (mb_busy[i]) mb_busy[i] = 0;
      if (b_wr_en && b_wr_addr != 0) begin
        mb_reg[b_wr_addr]  = b_wr_data;
        mb_busy[b_wr_addr] = 0;
      end
      if (b_rsv_en && b_rsv_addr != 0) mb_busy[b_rsv_addr] = 1;
    end
  end
  always @(negedge clk) begin : cmp
    logic [4:0] aa;
    logic [3:0] ba;
    bit         fa;
    int         ca, cb;
    ca = 0;
    cb = 0;
    foreach (ma_busy[i]) ca += int'(ma_busy[i]);
    foreach (mb_busy[i]) cb += int'(mb_busy[i]);
    chk("a_busy_cnt", a_busy_cnt, ca);
    chk("b_busy_cnt", b_busy_cnt, cb);
    for (int k = 0; k < 2; k++) begin
      aa = a_rd_addr[k*5 +: 5];
      fa = reset && a_wr_en && a_wr_addr == aa;
      chk($sformatf("a_rd_data%0d", k), a_rd_data[k*32 +: 32],
          aa == 0 ? 64'd0 : fa ? 64'(a_wr_data) : 64'(ma_reg[aa]));
      chk($sformatf("a_rd_busy%0d", k), a_rd_busy[k], aa != 0 && !fa && ma_busy[aa]);
    end
    for (int k = 0; k < 3; k++) begin
      ba = b_rd_addr[k*4 +: 4];
      chk($sformatf("b_rd_data%0d", k), b_rd_data[k*64 +: 64], ba == 0 ? 64'd0 : mb_reg[ba]);
      chk($sformatf("b_rd_busy%0d", k), b_rd_busy[k], ba != 0 && mb_busy[ba]);
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    a_wr_en = 0; a_rsv_en = 0; a_flush = 0;
    b_wr_en = 0; b_rsv_en = 0; b_flush = 0;
  endtask
  initial begin
    model_clear();
    idle();
    a_rd_addr = '0; a_wr_addr = '0; a_wr_data = '0; a_rsv_addr = '0;
    b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0; b_rsv_addr = '0;
    repeat (2) cyc();
    chk("rst_hold_data", a_rd_data, 64'd0);
    chk("rst_hold_cnt", a_busy_cnt, 6'd0);
    reset = 1;
    a_wr_en = 1; a_wr_addr = 5; a_wr_data = 32'hDEADBEEF; a_rsv_en = 1; a_rsv_addr = 6;
    cyc(); idle();
    a_rd_addr = {5'd6, 5'd5};
    #1 chk("preload_r5", a_rd_data[31:0], 32'hDEADBEEF);
    chk("preload_busy", a_rd_busy, 2'b10);
    chk("preload_cnt", a_busy_cnt, 6'd1);
    reset = 0;
    #1 chk("async_rst_data", a_rd_data, 64'd0);
    chk("async_rst_busy", a_rd_busy, 2'b00);
    chk("async_rst_cnt", a_busy_cnt, 6'd0);
    cyc();
    reset = 1;
    a_wr_en = 1; a_wr_addr = 7; a_wr_data = 32'h12345678;
    cyc(); idle();
    a_rd_addr = {5'd7, 5'd7};
    #1 chk("wr_rd_r7", a_rd_data, {32'h12345678, 32'h12345678});
    a_wr_en = 1; a_wr_addr = 0; a_wr_data = 32'hFFFFFFFF; a_rd_addr = {5'd0, 5'd0};
    #1 chk("r0_wr_cycle", a_rd_data, 64'd0);
    cyc(); idle();
    #1 chk("r0_after", a_rd_data, 64'd0);
    a_wr_en = 1; a_wr_addr = 3; a_wr_data = 32'hA5A5A5A5; a_rd_addr = {5'd7, 5'd3};
    #1 chk("bypass", a_rd_data, {32'h12345678, 32'hA5A5A5A5});
    cyc(); idle();
    a_rsv_en = 1; a_rsv_addr = 9; a_rd_addr = {5'd9, 5'd9};
    #1 chk("rsv_same_cycle", a_rd_busy, 2'b00);
    cyc(); idle();
    #1 chk("rsv_busy", a_rd_busy, 2'b11);
    chk("rsv_cnt", a_busy_cnt, 6'd1);
    a_wr_en = 1; a_wr_addr = 9; a_wr_data = 32'h55;
    #1 chk("wr_mask_busy", a_rd_busy, 2'b00);
    chk("wr_fwd_data", a_rd_data[31:0], 32'h55);
    cyc(); idle();
    #1 chk("wr_clr_busy", a_rd_busy, 2'b00);
    chk("wr_clr_cnt", a_busy_cnt, 6'd0);
    a_rsv_en = 1; a_rsv_addr = 9;
    cyc();
    a_wr_en = 1; a_wr_addr = 9; a_wr_data = 32'h66;
    cyc(); idle();
    #1 chk("rsv_wr_busy", a_rd_busy, 2'b11);
    chk("rsv_wr_cnt", a_busy_cnt, 6'd1);
    chk("rsv_wr_data", a_rd_data[31:0], 32'h66);
    a_flush = 1;
    cyc(); idle();
    #1 chk("flush_cnt", a_busy_cnt, 6'd0);
    for (int r = 1; r <= 3; r++) begin
      a_rsv_en = 1; a_rsv_addr = 5'(r);
      cyc();
    end
    idle();
    #1 chk("rsv3_cnt", a_busy_cnt, 6'd3);
    a_flush = 1; a_rsv_en = 1; a_rsv_addr = 4; a_rd_addr = {5'd1, 5'd4};
    cyc(); idle();
    #1 chk("flush_rsv_cnt", a_busy_cnt, 6'd1);
    chk("flush_rsv_busy", a_rd_busy, 2'b01);
    a_rsv_en = 1; a_rsv_addr = 0;
    cyc(); idle();
    #1 chk("rsv_r0_cnt", a_busy_cnt, 6'd1);
    b_wr_en = 1; b_wr_addr = 3; b_wr_data = 64'hA5A5A5A5; b_rd_addr = {4'd3, 4'd3, 4'd3};
    #1 chk("b_nobypass_old", b_rd_data[63:0], 64'd0);
    cyc(); idle();
    #1 chk("b_after_wr", b_rd_data, {3{64'hA5A5A5A5}});
    b_rsv_en = 1; b_rsv_addr = 5;
    cyc(); idle();
    b_wr_en = 1; b_wr_addr = 5; b_wr_data = 64'h0123456789ABCDEF; b_rd_addr = {4'd5, 4'd3, 4'd0};
    #1 chk("b_busy_unmasked", b_rd_busy, 3'b100);
    chk("b_r0", b_rd_data[63:0], 64'd0);
    cyc(); idle();
    #1 chk("b_wr_clr", b_rd_busy, 3'b000);
    chk("b_wr_cnt", b_busy_cnt, 5'd0);
    chk("b_wr_data", b_rd_data[191:128], 64'h0123456789ABCDEF);
    for (int c = 0; c < 10000; c++) begin
      a_wr_en   = 1'($urandom_range(0, 1));
      a_wr_addr = 5'($urandom_range(0, 31));
      a_wr_data = $urandom;
      a_rsv_en  = 1'($urandom_range(0, 1));
      a_rsv_addr = $urandom_range(0, 1) ? a_wr_addr : 5'($urandom_range(0, 31));
      a_flush   = $urandom_range(0, 15) == 0;
      a_rd_addr = {5'($urandom_range(0, 31)), $urandom_range(0, 1) ? a_wr_addr : 5'($urandom_range(0, 31))};
      b_wr_en   = 1'($urandom_range(0, 1));
      b_wr_addr = 4'($urandom_range(0, 15));
      b_wr_data = {$urandom, $urandom};
      b_rsv_en  = 1'($urandom_range(0, 1));
      b_rsv_addr = $urandom_range(0, 1) ? b_wr_addr : 4'($urandom_range(0, 15));
      b_flush   = $urandom_range(0, 15) == 0;
      b_rd_addr = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   $urandom_range(0, 1) ? b_wr_addr : 4'($urandom_range(0, 15))};
      cyc();
      if (c == 5000) begin
        #2 reset = 0;
        cyc();
        reset = 1;
      end
    end
    idle();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
